// File: rtl/uart_rxd.sv
// uart_rxd: 8N1 UART receiver (LSB first, idle-high line) for the uart_txd link.
// A baud counter started on the start-bit edge samples each bit at its centre.
module uart_rxd #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rs232_rxd,
    output logic       o_baudrate_rx_clk_en,
    output logic [7:0] o_data,
    output logic       o_rx_done,
    output logic       o_frame_err
);
    localparam int unsigned BAUD_CNT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF_CNT = BAUD_CNT / 2;
    localparam int unsigned CNT_W    = $clog2(BAUD_CNT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CNT - 1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_nx;
    logic [2:0]       bit_cnt, bit_cnt_nx;
    logic [7:0]       shift, shift_nx;
    logic [7:0]       data_nx;
    logic             done_nx, err_nx;
    logic             rxd_m, rxd_s, rxd_d;
    logic             fall;

    // Synchronizer and delay flop reset high so leaving reset on an idle line is silent
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
            rxd_d <= 1'b1;
        end else begin
            rxd_m <= i_rs232_rxd;
            rxd_s <= rxd_m;
            rxd_d <= rxd_s;
        end
    end

    assign fall = ~rxd_s & rxd_d;

    always_comb begin
        state_nx   = state;
        clk_cnt_nx = clk_cnt + 1'b1;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift;
        data_nx    = o_data;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        unique case (state)
            IDLE: begin
                clk_cnt_nx = '0;
                bit_cnt_nx = '0;
                if (fall) state_nx = START;
            end
            START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_nx = '0;
                    bit_cnt_nx = '0;
                    state_nx   = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == BAUD_LAST) begin
                    clk_cnt_nx = '0;
                    shift_nx   = {rxd_s, shift[7:1]};
                    if (bit_cnt == 3'd7) state_nx = STOP;
                    else bit_cnt_nx = bit_cnt + 1'b1;
                end
            end
            STOP: begin
                if (clk_cnt == BAUD_LAST) begin
                    clk_cnt_nx = '0;
                    if (rxd_s) begin
                        data_nx  = shift;
                        done_nx  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line stays here rather than re-framing as 0x00 bytes
                clk_cnt_nx = '0;
                if (rxd_s) state_nx = IDLE;
            end
            default: begin
                clk_cnt_nx = '0;
                state_nx   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_nx;
            clk_cnt     <= clk_cnt_nx;
            bit_cnt     <= bit_cnt_nx;
            shift       <= shift_nx;
            o_data      <= data_nx;
            o_rx_done   <= done_nx;
            o_frame_err <= err_nx;
        end
    end

    always_comb o_baudrate_rx_clk_en = (state == START) || (state == DATA) || (state == STOP);

endmodule

// File: tb/tb_uart_rxd.sv
// tb_uart_rxd: drives prebuilt line waveforms into uart_rxd and checks every cycle
// against a model that decodes the same waveform from bit-centre timing arithmetic.
module tb_uart_rxd;
    localparam int unsigned CLK_FREQ  = 16_000;
    localparam int unsigned BAUD_RATE = 1_000;
    localparam int B = 16;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       en;
    logic [7:0] data;
    logic       done;
    logic       ferr;

    always #5 clk = ~clk;

    uart_rxd #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_rs232_rxd          (rxd),
        .o_baudrate_rx_clk_en (en),
        .o_data               (data),
        .o_rx_done            (done),
        .o_frame_err          (ferr)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    bit         line[$];
    bit         exp_done[];
    bit         exp_err[];
    bit         exp_en[];
    bit         exp_load[];
    logic [7:0] exp_byte[];
    logic [7:0] model_data = 8'h00;

    int cur_idx    = 0;
    bit cmp_active = 1'b0;
    int done_at[$];
    int err_cnt;
    int en_cnt;

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s @%0d: got %0h, expected %0h", name, idx, act, req);
        end
    endtask

    // Line level at index idx; outside the waveform the line is idle high
    function automatic bit ln(input int idx);
        if (idx < 0 || idx >= line.size()) return 1'b1;
        return line[idx];
    endfunction

    // line[n] is the pin level sampled at edge n; expectations are "just after edge n".
    // A 1->0 at n enters START at edge n+2; the pin seen at edge k is line[k-2].
    task automatic run_model();
        int len = line.size();
        int ext = len + 12 * B;
        int n, e, s, m;
        logic [7:0] d;
        exp_done = new[ext];
        exp_err  = new[ext];
        exp_en   = new[ext];
        exp_load = new[ext];
        exp_byte = new[ext];
        n = 1;
        while (n < len) begin
            if (!ln(n) && ln(n - 1)) begin
                e = n + 2;
                if (ln(e + H - 2)) begin
                    for (int k = e; k < e + H; k++) exp_en[k] = 1'b1;
                    n = e + H - 1;
                end else begin
                    for (int i = 0; i < 8; i++) d[i] = ln(e + H + (i + 1) * B - 2);
                    s = e + H + 9 * B;
                    for (int k = e; k < s; k++) exp_en[k] = 1'b1;
                    if (ln(s - 2)) begin
                        exp_done[s] = 1'b1;
                        exp_load[s] = 1'b1;
                        exp_byte[s] = d;
                        n = s - 1;
                    end else begin
                        exp_err[s] = 1'b1;
                        m = s;
                        while (!ln(m - 1)) m++;
                        n = m;
                    end
                end
            end else begin
                n++;
            end
        end
    endtask

    always @(posedge clk) begin
        if (cmp_active) begin
            #1;
            if (exp_load[cur_idx]) model_data = exp_byte[cur_idx];
            check("rx_done", cur_idx, 32'(done), 32'(exp_done[cur_idx]));
            check("frame_err", cur_idx, 32'(ferr), 32'(exp_err[cur_idx]));
            check("clk_en", cur_idx, 32'(en), 32'(exp_en[cur_idx]));
            check("data", cur_idx, 32'(data), 32'(model_data));
            if (done) done_at.push_back(cur_idx);
            if (ferr) err_cnt++;
            if (en) en_cnt++;
        end
    end

    task automatic push_level(input bit v, input int n);
        repeat (n) line.push_back(v);
    endtask

    task automatic push_frame(input logic [7:0] d, input bit stop);
        push_level(1'b0, B);
        for (int i = 0; i < 8; i++) push_level(d[i], B);
        push_level(stop, B);
    endtask

    task automatic run_phase();
        run_model();
        done_at.delete();
        err_cnt = 0;
        en_cnt  = 0;
        for (int n = 0; n < line.size(); n++) begin
            @(negedge clk);
            rxd        = line[n];
            cur_idx    = n;
            cmp_active = 1'b1;
        end
        @(negedge clk);
        cmp_active = 1'b0;
        rxd        = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", -1, 32'(data), 32'h00);
        check("reset_done", -1, 32'(done), 32'h0);
        check("reset_err", -1, 32'(ferr), 32'h0);
        check("reset_en", -1, 32'(en), 32'h0);
        rst = 1'b0;

        // Single 0x55: fall at line index 10, done at 10 + 2 + 8 + 9*16 = 164
        line.delete();
        push_level(1'b1, 10);
        push_frame(8'h55, 1'b1);
        push_level(1'b1, 12 * B);
        run_phase();
        check("model_latency", 164, 32'(exp_done[164]), 32'h1);
        check("count_55", -1, done_at.size(), 1);
        if (done_at.size() > 0) check("latency_55", -1, done_at[0], 164);
        check("data_55", -1, 32'(data), 32'h55);
        check("err_55", -1, err_cnt, 0);

        // Back-to-back frames: done pulses one frame length (160) apart
        line.delete();
        push_level(1'b1, 10);
        push_frame(8'hA5, 1'b1);
        push_frame(8'h3C, 1'b1);
        push_level(1'b1, 12 * B);
        run_phase();
        check("count_b2b", -1, done_at.size(), 2);
        if (done_at.size() == 2) check("spacing_b2b", -1, done_at[1] - done_at[0], 160);
        check("data_b2b", -1, 32'(data), 32'h3C);

        // Short low glitch: false start (en high 8 cycles), then 0x81 (en high 152)
        line.delete();
        push_level(1'b1, 20);
        push_level(1'b0, 3);
        push_level(1'b1, 40);
        push_frame(8'h81, 1'b1);
        push_level(1'b1, 12 * B);
        run_phase();
        check("en_cycles_glitch", -1, en_cnt, 160);
        check("count_glitch", -1, done_at.size(), 1);
        check("err_glitch", -1, err_cnt, 0);
        check("data_glitch", -1, 32'(data), 32'h81);

        // Stop bit low, held low two more bits, then 0x12
        line.delete();
        push_level(1'b1, 10);
        push_frame(8'hFF, 1'b0);
        push_level(1'b0, 2 * B);
        push_level(1'b1, 2 * B);
        push_frame(8'h12, 1'b1);
        push_level(1'b1, 12 * B);
        run_phase();
        check("err_count_break", -1, err_cnt, 1);
        check("done_count_break", -1, done_at.size(), 1);
        check("data_break", -1, 32'(data), 32'h12);

        // Reset during data bit 4 of 0x6B
        line.delete();
        push_level(1'b1, 10);
        push_frame(8'h6B, 1'b1);
        line = line[0 : 10 + 5 * B + H - 1];
        run_phase();
        check("en_before_reset", -1, 32'(en), 32'h1);
        rst = 1'b1;
        #1;
        check("abort_data", -1, 32'(data), 32'h00);
        check("abort_en", -1, 32'(en), 32'h0);
        check("abort_done", -1, 32'(done), 32'h0);
        check("abort_err", -1, 32'(ferr), 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold_pulse", i, 32'(done | ferr), 32'h0);
        end
        rst        = 1'b0;
        model_data = 8'h00;
        line.delete();
        push_level(1'b1, 10);
        push_frame(8'hC3, 1'b1);
        push_level(1'b1, 12 * B);
        run_phase();
        check("data_after_reset", -1, 32'(data), 32'hC3);

        // All 256 byte values with idle gaps between frames
        line.delete();
        push_level(1'b1, 10);
        for (int b = 0; b < 256; b++) begin
            push_frame(8'(b), 1'b1);
            push_level(1'b1, 16);
        end
        push_level(1'b1, 12 * B);
        run_phase();
        check("count_sweep", -1, done_at.size(), 256);
        check("err_sweep", -1, err_cnt, 0);
        check("data_sweep", -1, 32'(data), 32'hFF);

        // Random mix of frames, gaps, glitches and framing errors
        line.delete();
        push_level(1'b1, 10);
        for (int i = 0; i < 60; i++) begin
            int r = $urandom_range(0, 7);
            if (r == 0) begin
                push_level(1'b0, $urandom_range(1, H - 1));
                push_level(1'b1, $urandom_range(1, 2 * B));
            end else if (r == 1) begin
                push_frame(8'($urandom), 1'b0);
                push_level(1'b0, $urandom_range(0, 3 * B));
                push_level(1'b1, $urandom_range(1, B));
            end else begin
                push_frame(8'($urandom), 1'b1);
                push_level(1'b1, $urandom_range(0, B));
            end
        end
        push_level(1'b1, 12 * B);
        run_phase();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
